// File: rtl/mem_req_sequencer.sv
// -----------------------------------------------------------------------------
// mem_req_sequencer
//
// Queues client read/write requests in a small FIFO and issues them one at a
// time to a memory register block. Exactly one request is outstanding: the
// sequencer waits for the memory response, or gives up after TIMEOUT cycles,
// then presents a single client response and holds it until it is accepted.
//
// Ports
//   CLK, RESET                       clock, synchronous active-high reset
//   REQ_VLD/REQ_RDY                  client request handshake (REQ_RDY = !full)
//   REQ_CMD/REQ_ADDR/REQ_DATA        0=read 1=write, word address, write data
//   MEM_VLD/MEM_CMD/MEM_ADDR/MEM_DATA registered request to memory (VLD pulses)
//   MEM_RSP_VLD/MEM_RSP_WR_STATUS/MEM_RSP_DATA  memory response
//   RSP_VLD/RSP_RDY                  client response handshake
//   RSP_CMD/RSP_DATA/RSP_STATUS      echoed cmd, read data, 0=ok 1=wr err 2=timeout
//   ERR_CNT                          saturating count of timeouts + stray responses
// -----------------------------------------------------------------------------
module mem_req_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic        REQ_CMD,
  input  logic [5:0]  REQ_ADDR,
  input  logic [31:0] REQ_DATA,
  output logic        MEM_VLD,
  output logic        MEM_CMD,
  output logic [5:0]  MEM_ADDR,
  output logic [31:0] MEM_DATA,
  input  logic        MEM_RSP_VLD,
  input  logic        MEM_RSP_WR_STATUS,
  input  logic [31:0] MEM_RSP_DATA,
  output logic        RSP_VLD,
  input  logic        RSP_RDY,
  output logic        RSP_CMD,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  RSP_STATUS,
  output logic [7:0]  ERR_CNT
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ENTRY_W = 1 + 6 + 32;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
  localparam logic [7:0]       ERR_MAX   = 8'hFF;
  localparam logic [1:0]       STATUS_OK      = 2'd0;
  localparam logic [1:0]       STATUS_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [TMR_W-1:0]   timer_r;
  logic [TMR_W-1:0]   timer_nxt_s;

  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] head_s;

  logic               capture_s;
  logic               timeout_s;
  logic               stray_s;

  logic               mem_vld_r;
  logic               mem_cmd_r;
  logic [5:0]         mem_addr_r;
  logic [31:0]        mem_data_r;
  logic               rsp_vld_r;
  logic               rsp_cmd_r;
  logic [31:0]        rsp_data_r;
  logic [1:0]         rsp_status_r;
  logic [7:0]         err_cnt_r;

  // A full FIFO refuses the push even if the head is popped on the same edge.
  assign full_s  = (count_r == CNT_FULL);
  assign push_s  = REQ_VLD & ~full_s;
  assign head_s  = fifo_mem_r[rd_ptr_r];
  assign REQ_RDY = ~full_s;

  // Next-state and event decode for the single-outstanding-request sequencer.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    stray_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stray_s = MEM_RSP_VLD;
        if (count_r != CNT_ZERO) begin
          pop_s       = 1'b1;
          timer_nxt_s = TMR_ZERO;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A response arriving in the timeout cycle still counts as a response.
        if (MEM_RSP_VLD) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (timer_r == TMR_LIMIT) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      ST_RESP: begin
        stray_s = MEM_RSP_VLD;
        // Returning to IDLE first keeps the next issue off the accept edge.
        if (RSP_RDY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = TMR_ZERO;
      end
    endcase
  end

  // State and wait-timer registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; no reset needed because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_s && !RESET) begin
      fifo_mem_r[wr_ptr_r] <= {REQ_CMD, REQ_ADDR, REQ_DATA};
    end
  end

  // Memory request: MEM_VLD pulses for one cycle, payload holds until next issue.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_vld_r  <= 1'b0;
      mem_cmd_r  <= 1'b0;
      mem_addr_r <= 6'd0;
      mem_data_r <= 32'd0;
    end else begin
      mem_vld_r <= pop_s;
      if (pop_s) begin
        {mem_cmd_r, mem_addr_r, mem_data_r} <= head_s;
      end
    end
  end

  // Client response: captured on response or timeout, held through RESP.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_vld_r    <= 1'b0;
      rsp_cmd_r    <= 1'b0;
      rsp_data_r   <= 32'd0;
      rsp_status_r <= STATUS_OK;
    end else begin
      rsp_vld_r <= (state_nxt_s == ST_RESP);
      if (capture_s) begin
        rsp_cmd_r    <= mem_cmd_r;
        rsp_data_r   <= mem_cmd_r ? 32'd0 : MEM_RSP_DATA;
        rsp_status_r <= mem_cmd_r ? {1'b0, MEM_RSP_WR_STATUS} : STATUS_OK;
      end else if (timeout_s) begin
        rsp_cmd_r    <= mem_cmd_r;
        rsp_data_r   <= 32'd0;
        rsp_status_r <= STATUS_TIMEOUT;
      end
    end
  end

  // Error counter: timeouts and stray responses, saturating at 255.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_cnt_r <= 8'd0;
    end else if ((timeout_s || stray_s) && (err_cnt_r != ERR_MAX)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign MEM_VLD    = mem_vld_r;
  assign MEM_CMD    = mem_cmd_r;
  assign MEM_ADDR   = mem_addr_r;
  assign MEM_DATA   = mem_data_r;
  assign RSP_VLD    = rsp_vld_r;
  assign RSP_CMD    = rsp_cmd_r;
  assign RSP_DATA   = rsp_data_r;
  assign RSP_STATUS = rsp_status_r;
  assign ERR_CNT    = err_cnt_r;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_req_sequencer
//
// Self-checking bench for mem_req_sequencer. A transaction-level model (request
// queue, outstanding/holding flags, wait age, error count) predicts every output
// and is compared once per cycle on the falling edge. A memory stub answers
// issued requests after a chosen delay. Directed scenarios add literal
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_req_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VLD = 1'b0;
  logic        REQ_RDY;
  logic        REQ_CMD = 1'b0;
  logic [5:0]  REQ_ADDR = 6'd0;
  logic [31:0] REQ_DATA = 32'd0;
  logic        MEM_VLD;
  logic        MEM_CMD;
  logic [5:0]  MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        MEM_RSP_VLD = 1'b0;
  logic        MEM_RSP_WR_STATUS = 1'b0;
  logic [31:0] MEM_RSP_DATA = 32'd0;
  logic        RSP_VLD;
  logic        RSP_RDY = 1'b0;
  logic        RSP_CMD;
  logic [31:0] RSP_DATA;
  logic [1:0]  RSP_STATUS;
  logic [7:0]  ERR_CNT;

  mem_req_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_CMD(REQ_CMD),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .MEM_VLD(MEM_VLD), .MEM_CMD(MEM_CMD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MEM_RSP_VLD(MEM_RSP_VLD), .MEM_RSP_WR_STATUS(MEM_RSP_WR_STATUS),
    .MEM_RSP_DATA(MEM_RSP_DATA),
    .RSP_VLD(RSP_VLD), .RSP_RDY(RSP_RDY), .RSP_CMD(RSP_CMD),
    .RSP_DATA(RSP_DATA), .RSP_STATUS(RSP_STATUS), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Behavioural model state.
  typedef struct packed {
    logic        cmd;
    logic [5:0]  addr;
    logic [31:0] data;
  } req_t;
  req_t        q[$];
  bit          m_busy = 1'b0;   // request issued, no response yet
  bit          m_hold = 1'b0;   // response presented to client
  int          m_age = 0;       // cycles since issue
  logic        m_mem_vld = 1'b0;
  logic        m_mem_cmd = 1'b0;
  logic [5:0]  m_mem_addr = 6'd0;
  logic [31:0] m_mem_data = 32'd0;
  logic        m_rsp_cmd = 1'b0;
  logic [31:0] m_rsp_data = 32'd0;
  logic [1:0]  m_rsp_status = 2'd0;
  int          m_err = 0;

  // Memory stub and bookkeeping.
  logic [31:0] stub_mem [64];
  bit stub_auto = 1'b0;
  int rsp_delay = 2;
  int fixed_delay = 2;
  bit rand_delay = 1'b0;
  int stray_pm = 0;
  bit wr_err_en = 1'b0;
  int n_mv = 0;
  int n_hs = 0;
  bit saw_rsp = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    req_t e;
    bit   accept;
    if (RESET) begin
      q.delete();
      m_busy = 1'b0; m_hold = 1'b0; m_age = 0; m_err = 0;
      m_mem_vld = 1'b0; m_mem_cmd = 1'b0; m_mem_addr = 6'd0; m_mem_data = 32'd0;
      m_rsp_cmd = 1'b0; m_rsp_data = 32'd0; m_rsp_status = 2'd0;
      return;
    end
    accept = REQ_VLD && (q.size() < DEPTH);
    m_mem_vld = 1'b0;
    if (m_busy) begin
      if (MEM_RSP_VLD) begin
        m_rsp_cmd    = m_mem_cmd;
        m_rsp_data   = m_mem_cmd ? 32'd0 : MEM_RSP_DATA;
        m_rsp_status = m_mem_cmd ? {1'b0, MEM_RSP_WR_STATUS} : 2'd0;
        m_busy = 1'b0; m_hold = 1'b1;
      end else if (m_age == TMO) begin
        m_rsp_cmd = m_mem_cmd; m_rsp_data = 32'd0; m_rsp_status = 2'd2;
        if (m_err < 255) m_err++;
        m_busy = 1'b0; m_hold = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      if (MEM_RSP_VLD && m_err < 255) m_err++;
      if (m_hold) begin
        if (RSP_RDY) m_hold = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_mem_cmd = e.cmd; m_mem_addr = e.addr; m_mem_data = e.data;
        m_mem_vld = 1'b1; m_busy = 1'b1; m_age = 0;
      end
    end
    if (accept) begin
      e.cmd = REQ_CMD; e.addr = REQ_ADDR; e.data = REQ_DATA;
      q.push_back(e);
    end
  endtask

  // One clock cycle: stub response, model update, edge, settle past falling edge.
  task automatic tick();
    bit genuine;
    if (RSP_VLD === 1'b1 && RSP_RDY && !RESET) n_hs++;
    if (stub_auto) begin
      genuine = m_busy && (m_age == rsp_delay);
      MEM_RSP_VLD = genuine || ($urandom_range(0, 999) < stray_pm);
      MEM_RSP_WR_STATUS = wr_err_en ? 1'($urandom_range(0, 1)) : 1'b0;
      MEM_RSP_DATA = (genuine && !m_mem_cmd) ? stub_mem[m_mem_addr] : $urandom;
      if (genuine && m_mem_cmd && !MEM_RSP_WR_STATUS) stub_mem[m_mem_addr] = m_mem_data;
    end
    model_edge();
    if (m_mem_vld) rsp_delay = rand_delay ? int'($urandom_range(0, 18)) : fixed_delay;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    #1;
    if (MEM_VLD === 1'b1) n_mv++;
    if (RSP_VLD === 1'b1) saw_rsp = 1'b1;
  endtask

  // Compare every DUT output against the model once per cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("REQ_RDY",    32'(REQ_RDY),    32'(q.size() < DEPTH));
      chk("MEM_VLD",    32'(MEM_VLD),    32'(m_mem_vld));
      chk("MEM_CMD",    32'(MEM_CMD),    32'(m_mem_cmd));
      chk("MEM_ADDR",   32'(MEM_ADDR),   32'(m_mem_addr));
      chk("MEM_DATA",   MEM_DATA,        m_mem_data);
      chk("RSP_VLD",    32'(RSP_VLD),    32'(m_hold));
      chk("RSP_CMD",    32'(RSP_CMD),    32'(m_rsp_cmd));
      chk("RSP_DATA",   RSP_DATA,        m_rsp_data);
      chk("RSP_STATUS", 32'(RSP_STATUS), 32'(m_rsp_status));
      chk("ERR_CNT",    32'(ERR_CNT),    32'(m_err));
    end
  end

  task automatic do_reset();
    RESET = 1'b1; REQ_VLD = 1'b0; stub_auto = 1'b0; MEM_RSP_VLD = 1'b0;
    tick();
    RESET = 1'b0;
    chk_en = 1'b1;
  endtask

  // Wait (bounded) for MEM_VLD (which=0) or RSP_VLD (which=1); returns edge count.
  task automatic wait_sig(input int which, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && MEM_VLD === 1'b1) || (which == 1 && RSP_VLD === 1'b1)) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) begin
      n_checks++; n_errors++;
      $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
      c = cyc;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    RSP_RDY = 1'b1; REQ_VLD = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !m_busy && !m_hold) begin done = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL drain: queue not empty after 300 cycles, actual %0d required 0", q.size());
    end
  endtask

  initial begin
    int ta, c_mv, c_rv, pushed;
    bit saw_full;
    for (int i = 0; i < 64; i++) stub_mem[i] = 32'd0;

    // Reset state.
    do_reset();
    chk("rst_REQ_RDY", 32'(REQ_RDY), 32'd1);
    chk("rst_MEM_VLD", 32'(MEM_VLD), 32'd0);
    chk("rst_RSP_VLD", 32'(RSP_VLD), 32'd0);
    chk("rst_ERR_CNT", 32'(ERR_CNT), 32'd0);

    // Write then read address 5 with nominal memory latency.
    stub_auto = 1'b1; fixed_delay = 2; rand_delay = 1'b0; stray_pm = 0; wr_err_en = 1'b0;
    RSP_RDY = 1'b1;
    REQ_VLD = 1'b1; REQ_CMD = 1'b1; REQ_ADDR = 6'd5; REQ_DATA = 32'hDEADBEEF;
    tick(); ta = cyc; REQ_VLD = 1'b0;
    wait_sig(0, 20, c_mv);
    chk("issue_latency", 32'(c_mv - ta), 32'd1);
    wait_sig(1, 40, c_rv);
    chk("wr_rsp_latency", 32'(c_rv - c_mv), 32'd3);
    chk("wr_rsp_cmd", 32'(RSP_CMD), 32'd1);
    chk("wr_rsp_data", RSP_DATA, 32'd0);
    chk("wr_rsp_status", 32'(RSP_STATUS), 32'd0);
    tick();
    REQ_VLD = 1'b1; REQ_CMD = 1'b0; REQ_ADDR = 6'd5; REQ_DATA = 32'd0;
    tick(); REQ_VLD = 1'b0;
    wait_sig(0, 20, c_mv);
    wait_sig(1, 40, c_rv);
    chk("rd_rsp_latency", 32'(c_rv - c_mv), 32'd3);
    chk("rd_rsp_cmd", 32'(RSP_CMD), 32'd0);
    chk("rd_rsp_data", RSP_DATA, 32'hDEADBEEF);
    chk("rd_rsp_status", 32'(RSP_STATUS), 32'd0);
    drain();

    // Six back-to-back requests: FIFO fills, all issued and answered in order.
    do_reset();
    stub_auto = 1'b1; RSP_RDY = 1'b1; n_mv = 0; n_hs = 0; pushed = 0; saw_full = 1'b0;
    for (int g = 0; g < 100 && pushed < 6; g++) begin
      REQ_VLD = 1'b1; REQ_CMD = 1'($urandom_range(0, 1));
      REQ_ADDR = 6'(pushed); REQ_DATA = $urandom;
      if (REQ_RDY) pushed++; else saw_full = 1'b1;
      tick();
    end
    REQ_VLD = 1'b0;
    for (int g = 0; g < 200 && n_hs < 6; g++) tick();
    chk("b2b_full_seen", 32'(saw_full), 32'd1);
    chk("b2b_mem_vld_cnt", 32'(n_mv), 32'd6);
    chk("b2b_rsp_cnt", 32'(n_hs), 32'd6);
    chk("b2b_last_addr", 32'(MEM_ADDR), 32'd5);
    chk("b2b_err_cnt", 32'(ERR_CNT), 32'd0);

    // Memory never answers: timeout response, then a late stray response.
    do_reset();
    stub_auto = 1'b1; fixed_delay = 100; RSP_RDY = 1'b1;
    REQ_VLD = 1'b1; REQ_CMD = 1'b0; REQ_ADDR = 6'd9;
    tick(); REQ_VLD = 1'b0;
    wait_sig(0, 20, c_mv);
    wait_sig(1, 60, c_rv);
    chk("tmo_latency", 32'(c_rv - c_mv), 32'(TMO + 1));
    chk("tmo_status", 32'(RSP_STATUS), 32'd2);
    chk("tmo_data", RSP_DATA, 32'd0);
    chk("tmo_err_cnt", 32'(ERR_CNT), 32'd1);
    tick();
    stub_auto = 1'b0; MEM_RSP_VLD = 1'b1; tick(); MEM_RSP_VLD = 1'b0; tick();
    chk("late_err_cnt", 32'(ERR_CNT), 32'd2);

    // Client stalls the response for 10 cycles.
    do_reset();
    stub_auto = 1'b1; fixed_delay = 2; RSP_RDY = 1'b0;
    REQ_VLD = 1'b1; REQ_CMD = 1'b1; REQ_ADDR = 6'd1; REQ_DATA = 32'h0000_1234;
    wait_sig(1, 40, c_rv);
    n_mv = 0;
    repeat (10) tick();
    chk("stall_rsp_vld", 32'(RSP_VLD), 32'd1);
    chk("stall_rsp_cmd", 32'(RSP_CMD), 32'd1);
    chk("stall_rsp_data", RSP_DATA, 32'd0);
    chk("stall_no_issue", 32'(n_mv), 32'd0);
    chk("stall_req_rdy", 32'(REQ_RDY), 32'd0);
    drain();

    // Reset in the middle of a wait with two requests queued.
    do_reset();
    stub_auto = 1'b1; fixed_delay = 100; RSP_RDY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      REQ_VLD = 1'b1; REQ_CMD = 1'b0; REQ_ADDR = 6'(k + 2); REQ_DATA = 32'd0;
      tick();
    end
    REQ_VLD = 1'b0;
    tick(); tick();
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("mrst_req_rdy", 32'(REQ_RDY), 32'd1);
    chk("mrst_mem_vld", 32'(MEM_VLD), 32'd0);
    chk("mrst_mem_addr", 32'(MEM_ADDR), 32'd0);
    chk("mrst_rsp_vld", 32'(RSP_VLD), 32'd0);
    chk("mrst_err_cnt", 32'(ERR_CNT), 32'd0);
    stub_auto = 1'b0; MEM_RSP_VLD = 1'b1; tick(); MEM_RSP_VLD = 1'b0;
    n_mv = 0; saw_rsp = 1'b0;
    repeat (5) tick();
    chk("mrst_stray_err", 32'(ERR_CNT), 32'd1);
    chk("mrst_no_issue", 32'(n_mv), 32'd0);
    chk("mrst_no_rsp", 32'(saw_rsp), 32'd0);

    // 300 stray responses in IDLE saturate the error counter.
    do_reset();
    saw_rsp = 1'b0;
    repeat (300) begin
      MEM_RSP_VLD = 1'b1; tick();
      MEM_RSP_VLD = 1'b0; tick();
    end
    chk("sat_err_cnt", 32'(ERR_CNT), 32'd255);
    chk("sat_no_rsp", 32'(saw_rsp), 32'd0);

    // Randomized traffic with random latency, strays, stalls and resets.
    do_reset();
    stub_auto = 1'b1; rand_delay = 1'b1; stray_pm = 20; wr_err_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      REQ_VLD  = ($urandom_range(0, 99) < 60);
      REQ_CMD  = 1'($urandom_range(0, 1));
      REQ_ADDR = 6'($urandom_range(0, 63));
      REQ_DATA = $urandom;
      RSP_RDY  = ($urandom_range(0, 99) < 70);
      RESET    = ($urandom_range(0, 999) < 3);
      tick();
    end
    RESET = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, 4, request FIFO entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles before a timeout response SHALL be supported.
REQ-003 CLK  in  1  clock; all state SHALL update on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 REQ_VLD  in  1  client request valid.
REQ-006 REQ_RDY  out  1  request accepted when REQ_VLD&REQ_RDY at an edge.
REQ-007 REQ_CMD  in  1  0=read, 1=write.
REQ-008 REQ_ADDR  in  6  word address.
REQ-009 REQ_DATA  in  32  write data.
REQ-010 MEM_VLD, MEM_CMD, MEM_ADDR, MEM_DATA  out  1/1/6/32  registered request to the memory register block.
REQ-011 MEM_RSP_VLD, MEM_RSP_WR_STATUS, MEM_RSP_DATA  in  1/1/32  memory response.
REQ-012 RSP_VLD  out  1  client response valid.
REQ-013 RSP_RDY  in  1  client response accept.
REQ-014 RSP_CMD, RSP_DATA, RSP_STATUS  out  1/32/2  echoed command, read data, status (0=ok, 1=write error, 2=timeout).
REQ-015 ERR_CNT  out  8  saturating count of timeouts plus stray responses.

Function
REQ-016 REQ_RDY SHALL equal !full combinationally; a push SHALL be refused when full even if a pop occurs that edge.
REQ-017 FIFO SHALL store {CMD,ADDR,DATA} in order; pointers SHALL wrap modulo FIFO_DEPTH; count SHALL track 0..FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, WAIT, RESP; exactly one request SHALL be outstanding at a time.
REQ-019 IDLE with FIFO non-empty: on the edge, head SHALL be popped into MEM_CMD/ADDR/DATA, MEM_VLD<=1, timer<=0, state<=WAIT.
REQ-020 MEM_VLD SHALL be a single-cycle pulse (first WAIT cycle); MEM_CMD/ADDR/DATA SHALL hold until next issue.
REQ-021 WAIT: timer SHALL increment each cycle; MEM_RSP_VLD=1 SHALL capture RSP_DATA (read: MEM_RSP_DATA, write: 0), RSP_STATUS={1'b0,MEM_RSP_WR_STATUS} for writes, 0 for reads, and go to RESP.
REQ-022 WAIT with timer==TIMEOUT and MEM_RSP_VLD=0 SHALL set RSP_STATUS=2, RSP_DATA=0, increment ERR_CNT, go to RESP; MEM_RSP_VLD in that same cycle SHALL win (normal response, no timeout).
REQ-023 RSP_CMD SHALL echo the issued MEM_CMD.
REQ-024 RESP: RSP_VLD=1 and RSP_* stable until RSP_RDY=1 at an edge, then IDLE; next issue SHALL not occur on that same edge.
REQ-025 MEM_RSP_VLD in IDLE or RESP SHALL be ignored for data and SHALL increment ERR_CNT (saturating at 255).
REQ-026 Late response after timeout SHALL be treated as stray per REQ-025.
REQ-027 Nominal latency: MEM_VLD in cycle c, memory response in c+2, RSP_VLD first high in c+3.
REQ-028 Request accepted at edge t into empty FIFO with FSM IDLE SHALL produce MEM_VLD in cycle t+2 (first cycle after t+1 edge).

Reset
REQ-029 RESET SHALL, at the edge, flush the FIFO (count 0), set state IDLE, timer 0, ERR_CNT 0.
REQ-030 During/after reset: MEM_VLD=0, RSP_VLD=0, MEM_CMD/ADDR/DATA=0, RSP_CMD/DATA/STATUS=0, REQ_RDY=1 after reset deasserts.
REQ-031 Reset mid-WAIT or mid-RESP SHALL drop the in-flight transaction; its later memory response SHALL count as stray.
REQ-032 RESET SHALL take priority over every simultaneous push, pop or response event.

Verification
REQ-033 Write addr 5 data 0xDEADBEEF, then read addr 5 -> responses status 0 (cmd 1, data 0) then status 0 (cmd 0, data 0xDEADBEEF), each RSP_VLD at MEM_VLD cycle +3.
REQ-034 Push 6 requests back-to-back, RSP_RDY=1 -> REQ_RDY drops when 4 queued, all 6 issued in order, one MEM_VLD per response, ERR_CNT=0.
REQ-035 Memory stub never responds -> RSP_STATUS=2, RSP_DATA=0 after TIMEOUT WAIT cycles, ERR_CNT=1.
REQ-036 RSP_RDY held 0 for 10 cycles -> RSP_* stable, no further MEM_VLD, FIFO fills to 4 and REQ_RDY=0.
REQ-037 RESET asserted one cycle during WAIT with 2 queued -> all outputs at reset values, FIFO empty, dropped response raises ERR_CNT to 1.
REQ-038 MEM_RSP_VLD pulsed in IDLE 300 times -> ERR_CNT saturates at 255, no RSP_VLD.
